rd_fifo_fill_ctrl: RTL



---
 rtl/rd_fifo_fill_ctrl_pkg.sv | 24 ++
 rtl/rd_fifo_fill_ctrl_if.sv | 39 +++
 rtl/rd_fifo_fill_addr_gen.sv | 57 +++++
 rtl/rd_fifo_fill_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rd_fifo_fill_ctrl_pkg.sv
// Shared types and constants for the rd_fifo read-side fill controller.
package rd_fifo_fill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIFO_RST,
    ST_WAIT_SPACE,
    ST_CMD,
    ST_DATA,
    ST_DRAIN
  } state_e;

  localparam int CMD_LEN_W      = 8;
  // One more bit than the length field so a full 256-beat burst fits.
  localparam int BEAT_W         = CMD_LEN_W + 1;
  localparam int DEF_DATA_WIDTH = 128;

  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BYTES_PER_BEAT = bytes_per_beat(DEF_DATA_WIDTH);

endpackage

// File: rtl/rd_fifo_fill_ctrl_if.sv
// Memory read-command/data and rd_fifo write-port bundle for the fill controller.
interface rd_fifo_fill_ctrl_if
  import rd_fifo_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH_WIDTH = 10
);

  logic                        rd_cmd_valid;
  logic                        rd_cmd_ready;
  logic [ADDR_WIDTH-1:0]       rd_cmd_addr;
  logic [CMD_LEN_W-1:0]        rd_cmd_len;
  logic                        rd_data_valid;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_data_last;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_wr_data;
  logic                        fifo_rst;
  logic                        fifo_wr_full;
  logic [FIFO_DEPTH_WIDTH:0]   fifo_wr_water_level;

  modport master (
    output rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    input  rd_cmd_ready,
    input  rd_data_valid, rd_data, rd_data_last,
    output fifo_wr_en, fifo_wr_data, fifo_rst,
    input  fifo_wr_full, fifo_wr_water_level
  );

  modport slave (
    input  rd_cmd_valid, rd_cmd_addr, rd_cmd_len,
    output rd_cmd_ready,
    output rd_data_valid, rd_data, rd_data_last,
    input  fifo_wr_en, fifo_wr_data, fifo_rst,
    output fifo_wr_full, fifo_wr_water_level
  );

endinterface

// File: rtl/rd_fifo_fill_addr_gen.sv
// Frame walker: current burst byte address, beats still to fetch, and the
// size of the next burst (the lesser of a full burst and what remains).
module rd_fifo_fill_addr_gen
  import rd_fifo_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_LEN   = 64,
  parameter int FRAME_BASE  = 0,
  parameter int FRAME_BEATS = 115200,
  parameter int BPB         = BYTES_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [BEAT_W-1:0]     beats_o,
  output logic                  remain_zero_o
);

  localparam int REM_W = $clog2(FRAME_BEATS + 1);
  localparam int CMP_W = (REM_W > BEAT_W) ? REM_W : BEAT_W;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REM_W-1:0]      remain_q, remain_d;

  always_comb begin
    if (CMP_W'(remain_q) < CMP_W'(BURST_LEN)) beats_o = BEAT_W'(remain_q);
    else                                      beats_o = BEAT_W'(BURST_LEN);
  end

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    if (load_i) begin
      addr_d   = ADDR_WIDTH'(FRAME_BASE);
      remain_d = REM_W'(FRAME_BEATS);
    end else if (adv_i) begin
      addr_d   = addr_q + ADDR_WIDTH'(beats_o) * ADDR_WIDTH'(BPB);
      remain_d = remain_q - REM_W'(beats_o);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign addr_o        = addr_q;
  assign remain_zero_o = (remain_q == '0);

endmodule

// File: rtl/rd_fifo_fill_ctrl.sv
// Fetches one frame as fixed-size read bursts, only when rd_fifo has room for a
// whole burst, and streams returned beats into the FIFO write port.
// Define RD_FIFO_FILL_CTRL_ERR_CHK_EN to enable the sticky protocol error flag.
module rd_fifo_fill_ctrl
  import rd_fifo_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH       = 28,
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH_WIDTH = 10,
  parameter int BURST_LEN        = 64,
  parameter int FRAME_BASE       = 0,
  parameter int FRAME_BEATS      = 115200,
  parameter int RST_CYCLES       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start_i,
  rd_fifo_fill_ctrl_if.master  bus,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 err_o
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int LV_W = FIFO_DEPTH_WIDTH + 1;
  localparam int SP_W = (LV_W > BEAT_W) ? LV_W : BEAT_W;

  state_e                  state_q, state_d;
  logic [RC_W-1:0]         rst_cnt_q, rst_cnt_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                    load, adv, restart, cmd_load;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [BEAT_W-1:0]       beats;
  logic                    remain_zero;
  logic [LV_W-1:0]         free;
  logic                    space_ok, cnt_one, last_beat;
  logic                    wr_en_d, done_d;

  logic                    cmd_valid_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [CMD_LEN_W-1:0]    cmd_len_q;
  logic                    wr_en_q;
  logic [DATA_WIDTH-1:0]   wr_data_q;
  logic                    done_q;

  rd_fifo_fill_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .BURST_LEN   (BURST_LEN),
    .FRAME_BASE  (FRAME_BASE),
    .FRAME_BEATS (FRAME_BEATS),
    .BPB         (bytes_per_beat(DATA_WIDTH))
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .adv_i         (adv),
    .addr_o        (addr),
    .beats_o       (beats),
    .remain_zero_o (remain_zero)
  );

  assign free      = LV_W'(2 ** FIFO_DEPTH_WIDTH) - bus.fifo_wr_water_level;
  assign space_ok  = SP_W'(free) >= SP_W'(beats);
  assign cnt_one   = (beat_cnt_q == BEAT_W'(1));
  assign last_beat = bus.rd_data_valid && cnt_one;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    beat_cnt_d = beat_cnt_q;
    load       = 1'b0;
    adv        = 1'b0;
    restart    = 1'b0;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: if (frame_start_i) restart = 1'b1;
      ST_FIFO_RST: begin
        if (frame_start_i)          restart   = 1'b1;
        else if (rst_cnt_q == '0)   state_d   = ST_WAIT_SPACE;
        else                        rst_cnt_d = rst_cnt_q - RC_W'(1);
      end
      ST_WAIT_SPACE: begin
        if (frame_start_i) restart = 1'b1;
        else if (space_ok) state_d = ST_CMD;
      end
      ST_CMD: begin
        // A handshake wins over a same-cycle restart: the burst is in flight.
        if (bus.rd_cmd_ready) begin
          adv        = 1'b1;
          beat_cnt_d = beats;
          state_d    = frame_start_i ? ST_DRAIN : ST_DATA;
        end else if (frame_start_i) begin
          restart = 1'b1;
        end
      end
      ST_DATA: begin
        if (bus.rd_data_valid) beat_cnt_d = beat_cnt_q - BEAT_W'(1);
        if (frame_start_i) begin
          if (last_beat) restart = 1'b1;
          else           state_d = ST_DRAIN;
        end else if (bus.rd_data_valid) begin
          wr_en_d = 1'b1;
          if (cnt_one) begin
            if (remain_zero) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT_SPACE;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (bus.rd_data_valid) begin
          beat_cnt_d = beat_cnt_q - BEAT_W'(1);
          if (cnt_one) restart = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d   = ST_FIFO_RST;
      load      = 1'b1;
      rst_cnt_d = RC_W'(RST_CYCLES - 1);
    end
  end

  assign cmd_load = (state_d == ST_CMD) && (state_q != ST_CMD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      cmd_valid_q <= (state_d == ST_CMD);
      if (cmd_load) begin
        cmd_addr_q <= addr;
        cmd_len_q  <= CMD_LEN_W'(beats - BEAT_W'(1));
      end
      wr_en_q <= wr_en_d;
      if (wr_en_d) wr_data_q <= bus.rd_data;
      done_q  <= done_d;
    end
  end

  assign bus.rd_cmd_valid = cmd_valid_q;
  assign bus.rd_cmd_addr  = cmd_addr_q;
  assign bus.rd_cmd_len   = cmd_len_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.fifo_rst     = (state_q == ST_FIFO_RST);
  assign busy_o           = (state_q != ST_IDLE);
  assign frame_done_o     = done_q;

`ifdef RD_FIFO_FILL_CTRL_ERR_CHK_EN
  logic err_q, err_d, final_beat, bad_beat;

  always_comb begin
    final_beat = ((state_q == ST_DATA) || (state_q == ST_DRAIN)) && cnt_one;
    bad_beat   = bus.rd_data_valid &&
                 ((bus.rd_data_last != final_beat) || bus.fifo_wr_full ||
                  (state_q == ST_IDLE) || (state_q == ST_FIFO_RST) ||
                  (state_q == ST_WAIT_SPACE) || (state_q == ST_CMD));
    err_d      = frame_start_i ? 1'b0 : (err_q | bad_beat);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  // Without checking, the FIFO simply drops beats offered while full.
  logic unused_chk;
  assign unused_chk = ^{bus.rd_data_last, bus.fifo_wr_full};
  assign err_o      = 1'b0;
`endif

endmodule
